ysyx_22040729_ifu: RTL and testbench
====================================

// Module: ysyx_22040729_ifu
// PURPOSE
//   Instruction fetch unit, directly upstream of the instruction decoder.
//   Holds the PC and issues one fetch at a time to instruction memory over a valid/ready request channel.
//   Captures the 32-bit response and presents it, with its PC, to decode over a valid/ready handshake.
//   Accepts PC redirects (taken branch/JAL/JALR) from execute and discards any stale in-flight fetch.
// PARAMETERS
//   ADDR_WIDTH  64             PC / memory address width
//   INST_WIDTH  32             instruction width
//   RESET_PC    64'h80000000   PC loaded on reset
// PORTS
//   clk             in   1           clock; all state updates on rising edge
//   rst             in   1           synchronous, active-high reset
//   redirect_valid  in   1           1 = load redirect_pc this cycle (highest priority)
//   redirect_pc     in   ADDR_WIDTH  new PC; bits [1:0] ignored (forced 0)
//   imem_req_valid  out  1           fetch request valid
//   imem_req_ready  in   1           memory accepts request
//   imem_req_addr   out  ADDR_WIDTH  fetch address (= pc)
//   imem_rsp_valid  in   1           response valid (single-cycle pulse, no back-pressure)
//   imem_rsp_data   in   INST_WIDTH  fetched instruction
//   inst_valid      out  1           instruction valid to decode
//   inst_ready      in   1           decode consumes instruction
//   inst_out        out  INST_WIDTH  instruction to decoder
//   inst_pc         out  ADDR_WIDTH  PC of inst_out
// BEHAVIOUR
//   Reset (rst=1 at edge): pc<=RESET_PC, state<=S_REQ, drop<=0, inst_out<=0, inst_pc<=0.
//     During/after reset cycle: imem_req_valid=0, inst_valid=0 until first non-reset edge.
//   Outputs: imem_req_valid=(state==S_REQ)&&!rst_q; imem_req_addr=pc; inst_valid=(state==S_HOLD).
//   FSM, no redirect:
//     S_REQ : on imem_req_valid&&imem_req_ready -> S_WAIT. Else stay; pc/addr held stable.
//     S_WAIT: on imem_rsp_valid -> latch inst_out<=rsp_data, inst_pc<=pc, -> S_HOLD.
//             Response never earlier than the cycle after request handshake.
//     S_HOLD: inst_out/inst_pc stable; on inst_ready -> pc<=pc+4, -> S_REQ.
//   Redirect (redirect_valid=1) overrides; pc<={redirect_pc[ADDR_WIDTH-1:2],2'b00}:
//     S_REQ, no req handshake -> stay S_REQ; next cycle request at new pc.
//     S_REQ, req handshake same cycle -> S_WAIT with drop<=1 (old fetch in flight).
//     S_WAIT, no rsp -> drop<=1, stay S_WAIT.
//     S_WAIT, rsp same cycle -> discard rsp, -> S_REQ.
//     S_HOLD -> held instruction discarded (inst_valid=0 next cycle), -> S_REQ.
//       If inst_ready also 1 that cycle, the handshake still counts as consumed; pc is redirect_pc, not pc+4.
//   Drop: in S_WAIT with drop=1, rsp_valid discards data, clears drop, -> S_REQ (no inst_valid).
//   Handshake rules: imem_req_valid deasserts without ready only on redirect or rst.
//     inst_valid deasserts without inst_ready only on redirect or rst.
//   At most one outstanding fetch. Best case one instruction per 3 cycles (REQ, WAIT, HOLD).
//   pc+4 wraps modulo 2^ADDR_WIDTH (no overflow flag).
//   rst mid-transaction: all state cleared; a late response after reset is ignored (state S_REQ).
// TESTING
//   Reset, req_ready=1, rsp 1 cycle later = 32'h00100093 -> req addr 0x80000000; inst_valid with inst_out=0x00100093, inst_pc=0x80000000; next req 0x80000004.
//   inst_ready=0 for 5 cycles in S_HOLD -> inst_valid, inst_out, inst_pc stable; no new imem request.
//   req_ready=0 for 4 cycles -> req_valid held 1, addr unchanged 0x80000000.
//   Redirect to 0x80000100 while in S_WAIT; rsp data 0xDEADBEEF -> discarded, no inst_valid; next req addr 0x80000100.
//   Redirect to 0x80000203 in S_HOLD with inst_ready=1 -> next req addr 0x80000200; no pc+4 request.
//   rst asserted in S_WAIT, rsp arrives during reset -> ignored; first request after reset at 0x80000000.

Source files
------------

// File: rtl/ysyx_22040729_ifu.sv
// Instruction fetch unit: keeps the PC, issues one fetch at a time to imem and
// hands each returned instruction, tagged with its PC, to decode.
module ysyx_22040729_ifu #(
  parameter int unsigned             ADDR_WIDTH = 64,
  parameter int unsigned             INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  drop;
  logic                  rst_q;
  logic                  req_fire;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  // Outputs come straight from flops; rst_q masks the request for the cycle after reset.
  assign imem_req_valid = (state == S_REQ) && !rst_q;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect_tgt   = redirect_pc & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= S_REQ;
      drop     <= 1'b0;
      inst_out <= '0;
      inst_pc  <= '0;
      rst_q    <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      unique case (state)
        S_REQ: begin
          if (redirect_valid) pc <= redirect_tgt;
          if (req_fire) begin
            state <= S_WAIT;
            // A fetch launched in the redirect cycle targets the old PC.
            drop  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_tgt;
            if (imem_rsp_valid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              inst_out <= imem_rsp_data;
              inst_pc  <= pc;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_tgt;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + ADDR_WIDTH'(4);
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040729_ifu.sv
// Directed scenarios followed by randomized traffic, checked each cycle against
// a flag-based transaction model of the fetch unit and a simple imem model.
module tb_ysyx_22040729_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;

  ysyx_22040729_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch-unit flags.
  logic [63:0] m_pc;
  bit          m_busy, m_stale, m_hold, m_quiet;
  logic [31:0] m_inst;
  logic [63:0] m_ipc;

  // Instruction memory model: one pending response with a countdown.
  int          mem_cnt = 0;
  logic [63:0] mem_addr;
  int          fixed_d = 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0010_0093;
      64'h8000_0004: return 32'hDEAD_BEEF;
      default:       return a[31:0] ^ {a[63:32] ^ 32'h5A5A_C3C3} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit rv, input logic [63:0] rp,
                              input bit rr, input bit rsp, input logic [31:0] d, input bit ir);
    logic [63:0] tgt;
    bit          was_quiet;
    tgt = {rp[63:2], 2'b00};
    if (r) begin
      m_pc = RST_PC; m_busy = 0; m_stale = 0; m_hold = 0;
      m_inst = '0; m_ipc = '0; m_quiet = 1;
    end else begin
      was_quiet = m_quiet;
      m_quiet = 0;
      if (m_hold) begin
        if (rv) begin m_hold = 0; m_pc = tgt; end
        else if (ir) begin m_hold = 0; m_pc = m_pc + 64'd4; end
      end else if (m_busy) begin
        if (rsp) begin
          m_busy = 0;
          if (rv) begin m_stale = 0; m_pc = tgt; end
          else if (m_stale) m_stale = 0;
          else begin m_hold = 1; m_inst = d; m_ipc = m_pc; end
        end else if (rv) begin
          m_stale = 1; m_pc = tgt;
        end
      end else begin
        if (!was_quiet && rr) begin m_busy = 1; m_stale = rv; end
        if (rv) m_pc = tgt;
      end
    end
  endtask

  // One clock cycle: drive, predict, clock, then compare on the falling edge.
  task automatic step(input bit r, input bit rv, input logic [63:0] rp, input bit rr, input bit ir);
    bit          rsp, hs;
    logic [31:0] d;
    rsp = (mem_cnt == 1);
    d   = rsp ? mem_word(mem_addr) : $urandom;
    rst = r; redirect_valid = rv; redirect_pc = rp;
    imem_req_ready = rr; inst_ready = ir;
    imem_rsp_valid = rsp; imem_rsp_data = d;
    hs = imem_req_valid && rr && !r;
    if (hs) mem_addr = imem_req_addr;
    model_update(r, rv, rp, rr, rsp, d, ir);
    @(posedge clk);
    if (mem_cnt != 0) mem_cnt--;
    if (hs) mem_cnt = (fixed_d != 0) ? fixed_d : int'($urandom_range(1, 3));
    @(negedge clk);
    check("req_valid",  {63'd0, imem_req_valid}, {63'd0, !m_busy && !m_hold && !m_quiet});
    check("req_addr",   imem_req_addr, m_pc);
    check("inst_valid", {63'd0, inst_valid}, {63'd0, m_hold});
    check("inst_out",   {32'd0, inst_out}, {32'd0, m_inst});
    check("inst_pc",    inst_pc, m_ipc);
  endtask

  initial begin
    int rst_left;
    bit rv;
    logic [63:0] rp;
    rst = 1; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
    inst_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    @(negedge clk);

    // Reset, then request held off by memory for 4 cycles.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    check("stall_valid", {63'd0, imem_req_valid}, 64'd1);
    check("stall_addr", imem_req_addr, 64'h8000_0000);
    // Fetch 0x80000000, response one cycle later.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("first_inst", {32'd0, inst_out}, 64'h0010_0093);
    check("first_pc", inst_pc, 64'h8000_0000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    check("hold_valid", {63'd0, inst_valid}, 64'd1);
    check("hold_noreq", {63'd0, imem_req_valid}, 64'd0);
    step(0, 0, 0, 0, 1);
    check("next_addr", imem_req_addr, 64'h8000_0004);
    // Redirect while waiting; late DEADBEEF response must be dropped.
    fixed_d = 2;
    step(0, 0, 0, 1, 0);
    step(0, 1, 64'h8000_0100, 0, 0);
    step(0, 0, 0, 0, 0);
    check("drop_noinst", {63'd0, inst_valid}, 64'd0);
    check("redir_addr", imem_req_addr, 64'h8000_0100);
    // Redirect in HOLD together with inst_ready: redirect target wins over pc+4.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 64'h8000_0203, 0, 1);
    check("hold_redir_addr", imem_req_addr, 64'h8000_0200);
    check("hold_redir_inv", {63'd0, inst_valid}, 64'd0);
    // PC wraps past the top of the address space.
    fixed_d = 1;
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("wrap_addr", imem_req_addr, 64'd0);
    // Reset in WAIT, response lands during reset.
    fixed_d = 2;
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("post_rst_addr", imem_req_addr, 64'h8000_0000);
    check("post_rst_valid", {63'd0, imem_req_valid}, 64'd1);

    // Randomized traffic.
    fixed_d = 0;
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 4;
      rv = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else rp = 64'h8000_0000 + 64'($urandom_range(0, 1023));
      step(rst_left != 0, rv, rp, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      if (rst_left != 0) rst_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
